ccff_chain_seg: RTL and testbench
=================================

# ccff_chain_seg

Parametrised configuration-chain segment for the programmable fabric: a WIDTH-bit serial shift register loaded on the programming clock, driving true and complement configuration outputs to the routing muxes and LUTs. It tracks how many bits have been shifted, flags a fully loaded segment, and can be locked. A locked segment freezes its contents and becomes a combinational bypass, so downstream segments can be reprogrammed without disturbing it. It generalises the fixed single-bit inverter/buffer cells into a configurable storage-plus-drive element.

## Interface
- WIDTH, 16: configuration bits held by the segment (≥2).
- INVERT_OUT, 0: when 1, mem_out drives the complement of stored bits and mem_outb the true value.
- CNT_W, $clog2(WIDTH+1): shift-counter width (derived, not overridden).

- prog_clk  in  1  programming clock; all state on rising edge.
- prog_rst_n  in  1  reset, asynchronous assert, active-low.
- ccff_head  in  1  serial configuration data in.
- shift_en  in  1  shift one bit this cycle.
- lock  in  1  request lock (honoured only in FULL).
- commit  in  1  shadow-update strobe (used only with CCFF_SHADOW_EN).
- ccff_tail  out  1  serial data out to next segment.
- mem_out  out  WIDTH  configuration output.
- mem_outb  out  WIDTH  complement of mem_out, always.
- cfg_done  out  1  segment has received ≥WIDTH bits.
- locked  out  1  segment is in LOCKED.

## Operation
- Shift register sr[WIDTH-1:0]. On shift_en (not LOCKED): sr[0]<=ccff_head, sr[i]<=sr[i-1]. ccff_tail = sr[WIDTH-1].
- Counter cnt increments on each accepted shift, saturates at WIDTH. It is never decremented; extra bits pass through to ccff_tail.
- States, derived from cnt plus a lock flag:
  - EMPTY: cnt==0.
  - FILLING: 0<cnt<WIDTH.
  - FULL: cnt==WIDTH.
  - LOCKED: lock seen in FULL.
- Transitions: EMPTY→FILLING on the first shift; FILLING→FULL on the shift that makes cnt==WIDTH; FULL→LOCKED on lock. LOCKED is exited only by reset.
- lock in EMPTY/FILLING: ignored, no latching.
- In FULL, lock and shift_en in the same cycle: lock wins and the shift is dropped (sr unchanged).
- In LOCKED:
  - shift_en is ignored; sr and cnt are frozen.
  - ccff_tail = ccff_head combinationally (bypass).
- cfg_done = (state is FULL or LOCKED). locked = (state is LOCKED).
- Output drive: cfg = INVERT_OUT ? ~src : src; mem_out = cfg; mem_outb = ~cfg. src is sr, or the shadow register when CCFF_SHADOW_EN is defined.

## Timing
- Reset (async, prog_rst_n=0):
  - sr=0, cnt=0, lock flag=0, shadow=0.
  - ccff_tail=0, cfg_done=0, locked=0.
  - mem_out = INVERT_OUT ? all-ones : 0; mem_outb = its complement.
- Reset release is taken synchronously at the next prog_clk edge. Reset mid-shift discards all partial data.
- Shift latency: a bit on ccff_head at edge k appears on ccff_tail after edge k+WIDTH-1, i.e. WIDTH accepted shifts.
- cfg_done rises in the cycle after the WIDTH-th accepted shift edge.
- locked rises one cycle after lock is sampled in FULL. The bypass is active from that same edge.
- mem_out follows sr with zero added latency when there is no shadow.

## Configuration
- CCFF_SHADOW_EN defined:
  - Adds shadow[WIDTH-1:0], the only source of mem_out/mem_outb.
  - shadow<=sr on commit while in FULL or LOCKED; commit in EMPTY/FILLING is ignored.
  - If commit and shift_en occur in the same cycle, shadow captures the pre-shift sr.
  - Fabric outputs are glitch-free during shifting.
- CCFF_SHADOW_EN undefined:
  - No shadow; commit is unused.
  - mem_out tracks sr every shift.

## Test plan
- WIDTH=8, reset, shift 0xA5 MSB first (8 cycles) -> cfg_done=1 one cycle after the 8th edge; mem_out=0xA5, mem_outb=0x5A.
- WIDTH=8, 12 shifts of 0x5A3 stream -> cnt saturates at 8; first 4 bits emerge on ccff_tail in order; cfg_done stays 1.
- FULL with sr=0x3C, assert lock and shift_en together -> sr stays 0x3C, locked=1 next cycle; toggling ccff_head 0/1 then appears immediately on ccff_tail.
- lock asserted at cnt=5 -> ignored, locked=0; after 3 more shifts cfg_done=1, locked still 0.
- INVERT_OUT=1, reset -> mem_out=0xFF, mem_outb=0x00; load 0x0F -> mem_out=0xF0.
- CCFF_SHADOW_EN, load 0x81, commit -> mem_out=0x81; shift 4 more bits -> mem_out stays 0x81 until the next commit; prog_rst_n low mid-shift -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ccff_chain_seg.sv
// -----------------------------------------------------------------------------
// ccff_chain_seg
//
// One segment of the fabric configuration chain. Bits are shifted in serially
// on prog_clk, held in a WIDTH-bit shift register and driven out as true and
// complement configuration words to the routing muxes and LUTs. Once a segment
// has received WIDTH bits it is full and can be locked. A locked segment
// freezes its contents and passes ccff_head straight through to ccff_tail, so
// segments further down the chain can be reprogrammed without disturbing it.
//
// Optional feature (compile-time macro): CCFF_SHADOW_EN
//   When defined, a shadow register sits between the shift register and the
//   fabric outputs. It is loaded from the shift register on commit (only in
//   FULL or LOCKED), so mem_out/mem_outb stay stable while bits are shifting.
//   When undefined, mem_out follows the shift register directly and commit is
//   unused.
//
// Parameters
//   WIDTH      configuration bits held by the segment (>= 2)
//   INVERT_OUT 1: mem_out carries the complement of the stored bits
//   CNT_W      shift-counter width, derived from WIDTH
//
// Ports
//   prog_clk    in   programming clock, all state on rising edge
//   prog_rst_n  in   asynchronous active-low reset
//   ccff_head   in   serial configuration data in
//   shift_en    in   shift one bit this cycle
//   lock        in   lock request, honoured only when FULL
//   commit      in   shadow update strobe (CCFF_SHADOW_EN only)
//   ccff_tail   out  serial data out to the next segment
//   mem_out     out  configuration word
//   mem_outb    out  complement of mem_out
//   cfg_done    out  segment holds a full WIDTH-bit configuration
//   locked      out  segment is locked
// -----------------------------------------------------------------------------
module ccff_chain_seg #(
   parameter int WIDTH      = 16,
   parameter bit INVERT_OUT = 1'b0,
   localparam int CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             prog_clk,
   input  logic             prog_rst_n,
   input  logic             ccff_head,
   input  logic             shift_en,
   input  logic             lock,
   input  logic             commit,
   output logic             ccff_tail,
   output logic [WIDTH-1:0] mem_out,
   output logic [WIDTH-1:0] mem_outb,
   output logic             cfg_done,
   output logic             locked
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2,
      ST_LOCKED  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   logic [WIDTH-1:0] sr_r;
   logic [WIDTH-1:0] sr_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             lock_r;
   logic             lock_nxt_s;
   state_e           state_s;
   logic [WIDTH-1:0] src_s;
   logic [WIDTH-1:0] cfg_s;

   // State decode: the state is not stored separately, it is implied by the
   // shift count and the lock flag.
   always_comb begin
      state_s = ST_EMPTY;
      if (lock_r) begin
         state_s = ST_LOCKED;
      end else if (cnt_r == CNT_FULL) begin
         state_s = ST_FULL;
      end else if (cnt_r == CNT_ZERO) begin
         state_s = ST_EMPTY;
      end else begin
         state_s = ST_FILLING;
      end
   end

   // Next-state logic for shift register, counter and lock flag.
   always_comb begin
      sr_nxt_s   = sr_r;
      cnt_nxt_s  = cnt_r;
      lock_nxt_s = lock_r;
      case (state_s)
         ST_EMPTY, ST_FILLING: begin
            // lock is ignored here; nothing is latched for later
            if (shift_en) begin
               sr_nxt_s  = {sr_r[WIDTH-2:0], ccff_head};
               cnt_nxt_s = cnt_r + CNT_ONE;
            end else begin
               sr_nxt_s  = sr_r;
               cnt_nxt_s = cnt_r;
            end
         end
         ST_FULL: begin
            // lock beats a simultaneous shift; the counter stays saturated
            // and surplus bits simply flow on towards ccff_tail
            if (lock) begin
               lock_nxt_s = 1'b1;
            end else if (shift_en) begin
               sr_nxt_s = {sr_r[WIDTH-2:0], ccff_head};
            end else begin
               sr_nxt_s = sr_r;
            end
         end
         ST_LOCKED: begin
            // frozen until reset
            lock_nxt_s = 1'b1;
         end
         default: begin
            sr_nxt_s   = sr_r;
            cnt_nxt_s  = cnt_r;
            lock_nxt_s = lock_r;
         end
      endcase
   end

   // State registers: shift register, shift counter and lock flag.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         sr_r   <= {WIDTH{1'b0}};
         cnt_r  <= CNT_ZERO;
         lock_r <= 1'b0;
      end else begin
         sr_r   <= sr_nxt_s;
         cnt_r  <= cnt_nxt_s;
         lock_r <= lock_nxt_s;
      end
   end

`ifdef CCFF_SHADOW_EN
   logic [WIDTH-1:0] shadow_r;
   logic             commit_take_s;

   assign commit_take_s = commit && ((state_s == ST_FULL) || (state_s == ST_LOCKED));

   // Shadow register: samples the pre-shift contents of sr on an accepted
   // commit, so the fabric never sees partially shifted data.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         shadow_r <= {WIDTH{1'b0}};
      end else if (commit_take_s) begin
         shadow_r <= sr_r;
      end else begin
         shadow_r <= shadow_r;
      end
   end

   assign src_s = shadow_r;
`else
   logic unused_commit_s;

   assign unused_commit_s = commit;
   assign src_s           = sr_r;
`endif

   // Output drive: status flags, serial tail (bypassed when locked) and the
   // true/complement configuration words.
   always_comb begin
      cfg_done = (state_s == ST_FULL) || (state_s == ST_LOCKED);
      locked   = (state_s == ST_LOCKED);
      if (state_s == ST_LOCKED) begin
         ccff_tail = ccff_head;
      end else begin
         ccff_tail = sr_r[WIDTH-1];
      end
      if (INVERT_OUT) begin
         cfg_s = ~src_s;
      end else begin
         cfg_s = src_s;
      end
      mem_out  = cfg_s;
      mem_outb = ~cfg_s;
   end

endmodule

// File: tb/tb_ccff_chain_seg.sv
// -----------------------------------------------------------------------------
// tb_ccff_chain_seg
//
// Drives two WIDTH=8 segments (INVERT_OUT=0 and INVERT_OUT=1) with the same
// stimulus. A bit-history reference model produces the expected outputs for
// each cycle into a queue; a monitor pops one entry per clock and compares.
// -----------------------------------------------------------------------------
module tb_ccff_chain_seg;

   localparam int W = 8;

   logic         prog_clk = 1'b0;
   logic         prog_rst_n;
   logic         ccff_head, shift_en, lock, commit;
   logic         tail_a, done_a, locked_a;
   logic [W-1:0] mo_a, mob_a;
   logic         tail_b, done_b, locked_b;
   logic [W-1:0] mo_b, mob_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [W-1:0] mo;
      logic         done;
      logic         lk;
      logic         tail;
   } exp_t;

   exp_t exp_q[$];

   // reference model: most recent accepted bit first, at most W kept
   bit           hist[$];
   bit           m_lock;
   logic [W-1:0] m_shadow;

   ccff_chain_seg #(.WIDTH(W), .INVERT_OUT(1'b0)) dut (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .ccff_head(ccff_head),
      .shift_en(shift_en), .lock(lock), .commit(commit), .ccff_tail(tail_a),
      .mem_out(mo_a), .mem_outb(mob_a), .cfg_done(done_a), .locked(locked_a));

   ccff_chain_seg #(.WIDTH(W), .INVERT_OUT(1'b1)) dut_inv (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .ccff_head(ccff_head),
      .shift_en(shift_en), .lock(lock), .commit(commit), .ccff_tail(tail_b),
      .mem_out(mo_b), .mem_outb(mob_b), .cfg_done(done_b), .locked(locked_b));

   always #5 prog_clk = ~prog_clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [W-1:0] model_sr();
      logic [W-1:0] v;
      v = {W{1'b0}};
      for (int i = 0; i < hist.size(); i++) v[i] = hist[i];
      return v;
   endfunction

   function automatic logic [W-1:0] model_src();
`ifdef CCFF_SHADOW_EN
      return m_shadow;
`else
      return model_sr();
`endif
   endfunction

   // Monitor: one expected entry per clock edge, checked 1 time unit later.
   always @(posedge prog_clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("mem_out",       mo_a,            e.mo);
         chk("mem_outb",      mob_a,           ~e.mo);
         chk("inv_mem_out",   mo_b,            ~e.mo);
         chk("inv_mem_outb",  mob_b,           e.mo);
         chk("cfg_done",      {7'd0, done_a},  {7'd0, e.done});
         chk("locked",        {7'd0, locked_a}, {7'd0, e.lk});
         chk("ccff_tail",     {7'd0, tail_a},  {7'd0, e.tail});
         chk("inv_ccff_tail", {7'd0, tail_b},  {7'd0, e.tail});
         chk("inv_cfg_done",  {6'd0, done_b, locked_b}, {6'd0, e.done, e.lk});
      end
   end

   // One clock of stimulus; the model predicts the state after the next edge.
   task automatic step(input logic h, input logic sh, input logic lk, input logic cm);
      exp_t         e;
      logic [W-1:0] pre_sr;
      bit           pre_full;
      @(negedge prog_clk);
      ccff_head = h; shift_en = sh; lock = lk; commit = cm;
      pre_sr   = model_sr();
      pre_full = (hist.size() == W);
      if (cm && (pre_full || m_lock)) m_shadow = pre_sr;
      if (!m_lock) begin
         if (pre_full && lk) begin
            m_lock = 1'b1;
         end else if (sh) begin
            hist.push_front(h);
            if (hist.size() > W) void'(hist.pop_back());
         end
      end
      e.mo   = model_src();
      e.done = (hist.size() == W) || m_lock;
      e.lk   = m_lock;
      e.tail = m_lock ? h : model_sr()[W-1];
      exp_q.push_back(e);
   endtask

   // Asynchronous reset between clock edges; outputs checked before any edge.
   task automatic do_reset();
      @(negedge prog_clk);
      ccff_head = 1'b0; shift_en = 1'b0; lock = 1'b0; commit = 1'b0;
      #2;
      prog_rst_n = 1'b0;
      hist.delete();
      m_lock   = 1'b0;
      m_shadow = {W{1'b0}};
      #1;
      chk("rst_mem_out",      mo_a,  8'h00);
      chk("rst_mem_outb",     mob_a, 8'hFF);
      chk("rst_inv_mem_out",  mo_b,  8'hFF);
      chk("rst_inv_mem_outb", mob_b, 8'h00);
      chk("rst_flags", {3'd0, tail_a, done_a, locked_a, done_b, locked_b}, 8'h00);
      @(negedge prog_clk);
      prog_rst_n = 1'b1;
   endtask

   task automatic load(input logic [15:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) step(val[i], 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      prog_rst_n = 1'b0;
      ccff_head = 1'b0; shift_en = 1'b0; lock = 1'b0; commit = 1'b0;
      m_lock = 1'b0; m_shadow = {W{1'b0}};
      repeat (2) @(posedge prog_clk);
      do_reset();

      // 0xA5 MSB first, then commit (only matters with a shadow)
      load(16'h00A5, 8);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 12-bit stream: counter saturates, first bits emerge on the tail
      do_reset();
      load(16'h05A3, 12);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // lock and shift together in FULL, then bypass toggling
      do_reset();
      load(16'h003C, 8);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0);

      // lock while filling is ignored
      do_reset();
      load(16'h0015, 5);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      load(16'h0006, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 0x0F load (inverted instance shows 0xF0)
      do_reset();
      load(16'h000F, 8);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // 0x81, commit, four more shifts, commit, then reset mid-shift
      do_reset();
      load(16'h0081, 8);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      load(16'h000B, 4);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      load(16'h0002, 2);
      do_reset();

      // randomized traffic
      for (int r = 0; r < 8; r++) begin
         do_reset();
         for (int c = 0; c < 40; c++) begin
            step(1'($urandom), 1'($urandom_range(3) != 0),
                 1'($urandom_range(7) == 0), 1'($urandom_range(4) == 0));
         end
      end

      repeat (3) @(posedge prog_clk);
      #2;
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
